// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard/stall controller and its memory-wait FSM
package hazard_pkg;
  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_WAIT = 2'b01,
    M_ERR  = 2'b10
  } mem_state_e;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: data-memory handshake tracker; freezes the pipeline while an access is outstanding, flags timeouts
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ack,
  input  logic err_clr,
  output logic freeze,
  output logic mem_busy,
  output logic mem_timeout_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  mem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      M_IDLE: if (mem_req && !mem_ack) begin
        state_d = M_WAIT;
        cnt_d = CW'(1);
      end
      M_WAIT: if (mem_ack) begin
        state_d = M_IDLE;
        cnt_d = '0;
      end else if (cnt_q == CW'(MEM_TIMEOUT)) state_d = M_ERR;
      else cnt_d = cnt_q + CW'(1);
      M_ERR: if (err_clr) begin
        state_d = M_IDLE;
        cnt_d = '0;
      end
      default: begin
        state_d = M_IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= M_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // an ack in the waiting cycle completes the access, so that cycle runs normally
  assign freeze = (state_q == M_ERR) ||
                  (((state_q == M_WAIT) || ((state_q == M_IDLE) && mem_req)) && !mem_ack);
  assign mem_busy = (state_q == M_WAIT);
  assign mem_timeout_err = (state_q == M_ERR);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: per-cycle advance/hold/squash control for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add saturating stall_cycles/flush_count counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MEM_TIMEOUT = 15
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              err_clr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_en,
  output logic              mem_busy,
  output logic              mem_timeout_err
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0]   flush_count
`endif
);
  logic freeze, flush_req, lu_hit;
  logic ex_ld_v_q, ex_ld_v_d;
  logic [REG_AW-1:0] ex_ld_rd_q, ex_ld_rd_d;
  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .err_clr(err_clr),
    .freeze(freeze),
    .mem_busy(mem_busy),
    .mem_timeout_err(mem_timeout_err)
  );
  assign flush_req = ex_branch_taken || ex_jump;
  assign lu_hit = ex_ld_v_q && (ex_ld_rd_q != REG_AW'(REG_ZERO)) &&
                  ((id_rs_used && id_rs == ex_ld_rd_q) || (id_rt_used && id_rt == ex_ld_rd_q));
  always_comb begin
    pc_en = !reset && !freeze && (flush_req || !lu_hit);
    if_id_en = pc_en;
    ex_mem_en = !reset && !freeze;
    if_id_flush = ex_mem_en && flush_req;
    id_ex_bubble = reset || (!freeze && (flush_req || lu_hit));
    ex_ld_v_d = freeze ? ex_ld_v_q : id_ex_bubble ? 1'b0 : id_valid && id_is_load;
    ex_ld_rd_d = (freeze || id_ex_bubble) ? ex_ld_rd_q : id_rd;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_ld_v_q <= 1'b0;
      ex_ld_rd_q <= '0;
    end else begin
      ex_ld_v_q <= ex_ld_v_d;
      ex_ld_rd_q <= ex_ld_rd_d;
    end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic stall_inc, flush_inc;
  assign stall_inc = freeze || (lu_hit && !flush_req);
  assign flush_inc = !freeze && flush_req;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= (stall_inc && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
      flush_q <= (flush_inc && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
    end
  assign stall_cycles = stall_q;
  assign flush_count = flush_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scenarios plus randomized traffic against a behavioural pipeline-control model
module tb_hazard_stall_ctrl;
  logic clk = 0, reset = 1;
  logic id_valid, id_rs_used, id_rt_used, id_is_load;
  logic [4:0] id_rs, id_rt, id_rd;
  logic ex_branch_taken, ex_jump, mem_req, mem_ack, err_clr;
  logic pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_busy, mem_timeout_err;
  logic [6:0] obs;
  int total = 0, passed = 0;
  localparam logic [6:0] NORM = 7'b1100100, RST = 7'b0001000, FRZ = 7'b0000000,
                         FRZW = 7'b0000010, ERR = 7'b0000001, FLSH = 7'b1111100,
                         LU = 7'b0001100, ACKW = 7'b1100110;
  always #5 clk = ~clk;
  assign obs = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_busy, mem_timeout_err};
  hazard_stall_ctrl #(.REG_AW(5), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_load(id_is_load), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_req(mem_req), .mem_ack(mem_ack),
    .err_clr(err_clr), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en), .mem_busy(mem_busy),
    .mem_timeout_err(mem_timeout_err)
  );

  task automatic set_idle;
    {id_valid, id_rs_used, id_rt_used, id_is_load, ex_branch_taken, ex_jump, mem_req, mem_ack, err_clr} = '0;
    id_rs = 0; id_rt = 0; id_rd = 0;
  endtask

  task automatic nxt;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset;
    set_idle();
    #2;
    total++; if (obs !== RST) $display("FAIL reset_hold: got %b want %b", obs, RST); else passed++;
    nxt(); reset = 0; #1;
    total++; if (obs !== NORM) $display("FAIL reset_release: got %b want %b", obs, NORM); else passed++;
  endtask

  task automatic test_load_use;
    nxt(); id_valid = 1; id_is_load = 1; id_rd = 5; #1;
    total++; if (obs !== NORM) $display("FAIL lu_load: got %b want %b", obs, NORM); else passed++;
    nxt(); id_valid = 1; id_rs = 5; id_rs_used = 1; id_rd = 7; #1;
    total++; if (obs !== LU) $display("FAIL lu_stall: got %b want %b", obs, LU); else passed++;
    @(negedge clk); #1;
    total++; if (obs !== NORM) $display("FAIL lu_one_cycle: got %b want %b", obs, NORM); else passed++;
    nxt(); id_valid = 1; id_is_load = 1; id_rd = 0; #1;
    nxt(); id_valid = 1; id_rs = 0; id_rs_used = 1; id_rd = 3; #1;
    total++; if (obs !== NORM) $display("FAIL lu_r0: got %b want %b", obs, NORM); else passed++;
    nxt(); id_valid = 1; id_is_load = 1; id_rd = 9; #1;
    nxt(); id_valid = 1; id_rs = 9; id_rt = 9; id_rt_used = 1; #1;
    total++; if (obs !== LU) $display("FAIL lu_rt: got %b want %b", obs, LU); else passed++;
    nxt(); id_valid = 1; id_is_load = 1; id_rd = 9; #1;
    nxt(); id_valid = 1; id_rs = 9; id_rt = 9; #1;
    total++; if (obs !== NORM) $display("FAIL lu_unused: got %b want %b", obs, NORM); else passed++;
  endtask

  task automatic test_branch;
    nxt(); #1;
    nxt(); ex_branch_taken = 1; #1;
    total++; if (obs !== FLSH) $display("FAIL br_taken: got %b want %b", obs, FLSH); else passed++;
    nxt(); #1;
    total++; if (obs !== NORM) $display("FAIL br_after: got %b want %b", obs, NORM); else passed++;
    nxt(); ex_jump = 1; #1;
    total++; if (obs !== FLSH) $display("FAIL jump: got %b want %b", obs, FLSH); else passed++;
  endtask

  task automatic test_mem_wait;
    logic [6:0] exp_seq [5] = '{FRZ, FRZW, FRZW, ACKW, NORM};
    for (int i = 0; i < 5; i++) begin
      nxt(); mem_req = (i < 4); mem_ack = (i == 3); #1;
      total++; if (obs !== exp_seq[i]) $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, exp_seq[i]); else passed++;
    end
    nxt(); mem_req = 1; mem_ack = 1; #1;
    total++; if (obs !== NORM) $display("FAIL mem_zero_wait: got %b want %b", obs, NORM); else passed++;
    nxt(); #1;
    total++; if (obs !== NORM) $display("FAIL mem_zero_after: got %b want %b", obs, NORM); else passed++;
  endtask

  task automatic test_timeout;
    logic [6:0] e;
    for (int i = 0; i <= 15; i++) begin
      nxt(); mem_req = 1; #1;
      e = (i == 0) ? FRZ : FRZW;
      total++; if (obs !== e) $display("FAIL to_wait[%0d]: got %b want %b", i, obs, e); else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      nxt(); mem_ack = (i == 1); #1;
      total++; if (obs !== ERR) $display("FAIL to_sticky[%0d]: got %b want %b", i, obs, ERR); else passed++;
    end
    nxt(); err_clr = 1; #1;
    total++; if (obs !== ERR) $display("FAIL to_clr_cycle: got %b want %b", obs, ERR); else passed++;
    nxt(); #1;
    total++; if (obs !== NORM) $display("FAIL to_resume: got %b want %b", obs, NORM); else passed++;
    for (int i = 0; i <= 15; i++) begin
      nxt(); mem_req = 1; mem_ack = (i == 15); #1;
      e = (i == 0) ? FRZ : (i == 15) ? ACKW : FRZW;
      total++; if (obs !== e) $display("FAIL to_edge_ack[%0d]: got %b want %b", i, obs, e); else passed++;
    end
    nxt(); #1;
    total++; if (obs !== NORM) $display("FAIL to_edge_after: got %b want %b", obs, NORM); else passed++;
  endtask

  task automatic test_priority;
    logic [6:0] exp_seq [5] = '{FRZ, FRZW, FRZW, 7'b1111110, NORM};
    nxt(); #1;
    nxt(); id_valid = 1; id_is_load = 1; id_rd = 5; #1;
    for (int i = 0; i < 5; i++) begin
      nxt(); id_valid = 1; id_rs = 5; id_rs_used = 1; id_rd = 6;
      mem_req = (i < 4); mem_ack = (i == 3); ex_jump = (i < 4); #1;
      total++; if (obs !== exp_seq[i]) $display("FAIL prio[%0d]: got %b want %b", i, obs, exp_seq[i]); else passed++;
    end
  endtask

  task automatic test_async_reset;
    nxt(); mem_req = 1; #1;
    nxt(); mem_req = 1; #1;
    total++; if (obs !== FRZW) $display("FAIL ar_wait: got %b want %b", obs, FRZW); else passed++;
    #2 reset = 1; #1;
    total++; if (obs !== RST) $display("FAIL ar_immediate: got %b want %b", obs, RST); else passed++;
    nxt(); reset = 0; #1;
    total++; if (obs !== NORM) $display("FAIL ar_release: got %b want %b", obs, NORM); else passed++;
    nxt(); mem_req = 1; mem_ack = 1; #1;
    total++; if (obs !== NORM) $display("FAIL ar_idle_ack: got %b want %b", obs, NORM); else passed++;
  endtask

  task automatic test_random;
    int phase = 0, waited = 0, ld_rd = 0;
    bit ld_v = 0, frz, fl, lu;
    logic [6:0] e;
    nxt(); #1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      id_valid = $urandom_range(0, 1); id_is_load = $urandom_range(0, 1);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
      id_rs_used = $urandom_range(0, 1); id_rt_used = $urandom_range(0, 1);
      ex_branch_taken = ($urandom_range(0, 5) == 0); ex_jump = ($urandom_range(0, 9) == 0);
      mem_req = ($urandom_range(0, 2) == 0); mem_ack = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      #1;
      frz = (phase == 2) || ((phase == 1 || (phase == 0 && mem_req)) && !mem_ack);
      fl = ex_branch_taken || ex_jump;
      lu = ld_v && ld_rd != 0 && ((id_rs_used && id_rs == ld_rd) || (id_rt_used && id_rt == ld_rd));
      e = frz ? FRZ : fl ? FLSH : lu ? LU : NORM;
      e[1] = (phase == 1); e[0] = (phase == 2);
      total++; if (obs !== e) $display("FAIL rand[%0d]: got %b want %b", n, obs, e); else passed++;
      if (!frz) begin
        if (fl || lu) ld_v = 0;
        else begin ld_v = id_valid && id_is_load; ld_rd = id_rd; end
      end
      case (phase)
        0: if (mem_req && !mem_ack) begin phase = 1; waited = 1; end
        1: if (mem_ack) phase = 0; else if (waited == 15) phase = 2; else waited++;
        default: if (err_clr) phase = 0;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. Sits beside the forwarding/dependency logic and decides, every cycle, whether each pipeline register advances, holds, or is squashed. It covers three cases:
- load-use stalls that forwarding cannot cover;
- flushes on taken branches and jumps;
- a full-pipeline freeze while the data-memory handshake is outstanding, with timeout detection.

Parameters:
REG_AW, 5, register-address width.
MEM_TIMEOUT, 15, max wait cycles for mem_ack before error (>=1).
CNT_W, 16, perf counter width (used only with HAZARD_PERF_EN).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
id_valid  in  1  ID stage holds a real instruction.
id_rs  in  REG_AW  ID source register A.
id_rt  in  REG_AW  ID source register B.
id_rs_used  in  1  id_rs is read.
id_rt_used  in  1  id_rt is read.
id_is_load  in  1  ID instruction is a load.
id_rd  in  REG_AW  ID destination register.
ex_branch_taken  in  1  EX resolved conditional jump as taken.
ex_jump  in  1  EX holds unconditional jump.
mem_req  in  1  MEM stage requests data memory.
mem_ack  in  1  data memory completes access.
err_clr  in  1  clears timeout error.
pc_en  out  1  PC update enable.
if_id_en  out  1  IF/ID register enable.
if_id_flush  out  1  IF/ID loads NOP.
id_ex_bubble  out  1  ID/EX loads NOP.
ex_mem_en  out  1  EX/MEM and MEM/WB enable.
mem_busy  out  1  memory FSM is waiting.
mem_timeout_err  out  1  sticky timeout flag.

Behaviour:
- Internal state:
  - ex_ld_v/ex_ld_rd: tracks the load now in EX.
  - memory FSM: states M_IDLE, M_WAIT, M_ERR.
  - wait counter: ceil(log2(MEM_TIMEOUT+1)) bits.
- Outputs are combinational from registered state and current inputs; no added latency.
- While reset is high, outputs are forced to: pc_en=0, if_id_en=0, ex_mem_en=0, if_id_flush=0, id_ex_bubble=1, mem_busy=0, mem_timeout_err=0.
- Reset also clears state: FSM to M_IDLE, counter 0, ex_ld_v=0.
- Freeze: active when the FSM is in M_WAIT or M_ERR, or in M_IDLE with mem_req=1 and mem_ack=0.
  - Drives pc_en=if_id_en=ex_mem_en=0, id_ex_bubble=0, if_id_flush=0.
  - All registers hold.
- Flush: ex_branch_taken|ex_jump with no freeze.
  - Drives if_id_flush=1, id_ex_bubble=1, pc_en=1, if_id_en=1, ex_mem_en=1.
  - A flush request that arrives during a freeze stays asserted because EX is held; it takes effect in the first unfrozen cycle.
- Load-use: ex_ld_v, ex_ld_rd!=0, and (id_rs_used & id_rs==ex_ld_rd or id_rt_used & id_rt==ex_ld_rd).
  - Drives pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1.
  - Lasts exactly 1 cycle.
- Priority: freeze > flush > load-use > normal (all enables 1, no bubble/flush).
- Tracker update:
  - on freeze: hold;
  - on id_ex_bubble=1: ex_ld_v<=0;
  - otherwise: ex_ld_v<=id_valid&id_is_load, ex_ld_rd<=id_rd.
- Memory FSM:
  - M_IDLE: mem_req & mem_ack → stay, no freeze. mem_req & ~mem_ack → M_WAIT, counter<=1.
  - M_WAIT: mem_ack → M_IDLE, counter<=0. Otherwise, if counter==MEM_TIMEOUT → M_ERR; else counter+1.
  - mem_ack in the same cycle as counter==MEM_TIMEOUT counts as success.
  - M_ERR: mem_timeout_err=1, pipeline frozen. err_clr → M_IDLE, counter 0.
  - mem_ack outside M_WAIT or a mem_req cycle is ignored.
- mem_busy=1 in M_WAIT only.
- Reset asserted mid-wait aborts the access immediately, asynchronously.

Optional Feature:
HAZARD_PERF_EN:
- When defined, adds outputs stall_cycles[CNT_W] and flush_count[CNT_W]. Both are saturating counters, reset to 0.
  - stall_cycles increments on every freeze or load-use cycle.
  - flush_count increments on every flush cycle.
- When undefined, these ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg:
  - mem FSM state encoding (M_IDLE=2'b00, M_WAIT=2'b01, M_ERR=2'b10);
  - REG_ZERO=5'd0;
  - the NOP encoding used by flush/bubble.
- One sub-module, mem_wait_fsm: FSM plus counter. Outputs freeze, mem_busy, mem_timeout_err.

Test Plan:
- Load-use: ID load r5 then ID add reading r5 (id_rs=5) → 1 cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle normal; same sequence with rd=0 → no stall.
- Branch: ex_branch_taken=1 for 1 cycle → if_id_flush=1, id_ex_bubble=1, pc_en=1 that cycle only.
- Memory wait: mem_req=1, mem_ack arrives 3 cycles later → mem_busy=1 for 3 cycles, all enables 0 throughout, normal in the ack cycle; zero-wait ack → no freeze.
- Timeout: mem_req=1, no ack, MEM_TIMEOUT=15 → M_ERR entered after cycle 15, mem_timeout_err=1 sticky; err_clr → cleared, pipeline resumes.
- Priority: freeze with ex_jump=1 and a load-use hazard simultaneously → freeze only; after ack, flush wins and the load-use stall is suppressed (bubble clears tracker).
- Reset: assert reset during M_WAIT → outputs immediately take reset values without a clock edge; after deassert, FSM in M_IDLE and normal flow resumes.
